// File: rtl/updown_mod_counter.sv
// Modulo up/down counter with clear, clamped load, wrap/saturate boundary handling,
// enable prescaler, registered terminal-count pulse and sticky overflow flag.
module updown_mod_counter #(
  parameter int unsigned MAX_VALUE = 255,
  parameter int unsigned WRAP_MODE = 1,
  parameter int unsigned PRESCALE  = 1,
  localparam int unsigned WIDTH    = $clog2(MAX_VALUE + 1),
  localparam int unsigned PS_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic             clk_i,
  input  logic             a_rst_n_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] value_o,
  output logic             tc_o,
  output logic             ovf_o
);

  localparam logic [WIDTH:0]    MAX_EXT = (WIDTH + 1)'(MAX_VALUE);
  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [WIDTH-1:0]    value_q;
  logic [PS_WIDTH-1:0] ps_q;
  logic                tc_q;
  logic                ovf_q;

  logic [WIDTH:0] val_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] load_clamped;
  logic           step;
  logic           at_max;
  logic           at_zero;
  logic           boundary;

  always_comb begin
    val_ext      = {1'b0, value_q};
    load_ext     = {1'b0, load_value_i};
    load_clamped = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
    step         = enable_i && (ps_q == PS_LAST);
    at_max       = (val_ext == MAX_EXT);
    at_zero      = (val_ext == '0);
    boundary     = step && (up_i ? at_max : at_zero);
    step_ext     = val_ext;
    if (up_i) begin
      if (at_max) step_ext = (WRAP_MODE != 0) ? '0 : MAX_EXT;
      else        step_ext = val_ext + 1'b1;
    end else begin
      if (at_zero) step_ext = (WRAP_MODE != 0) ? MAX_EXT : '0;
      else         step_ext = val_ext - 1'b1;
    end
  end

  // Priority: clear > load > prescaled step; tc is only ever set by a boundary step.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      value_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      value_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      value_q <= WIDTH'(load_clamped);
      ps_q    <= '0;
      tc_q    <= 1'b0;
    end else if (enable_i) begin
      if (step) begin
        ps_q    <= '0;
        value_q <= WIDTH'(step_ext);
        tc_q    <= boundary;
        if (boundary) ovf_q <= 1'b1;
      end else begin
        ps_q <= ps_q + 1'b1;
        tc_q <= 1'b0;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign value_o = value_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: stimulus queues hand-computed expectations, monitors pop and compare.
module tb_updown_mod_counter;

  logic       clk;
  logic       rst_n;
  logic       en  [3];
  logic       clr [3];
  logic       ld  [3];
  logic       up  [3];
  logic [3:0] lv  [3];
  logic [3:0] val [3];
  logic       tc  [3];
  logic       ovf [3];

  typedef struct {
    int         d;
    logic [3:0] v;
    logic       tc;
    logic       ovf;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  event async_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  updown_mod_counter #(.MAX_VALUE(9), .WRAP_MODE(1), .PRESCALE(1)) d0 (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(en[0]), .clear_i(clr[0]), .load_i(ld[0]),
    .load_value_i(lv[0]), .up_i(up[0]), .value_o(val[0]), .tc_o(tc[0]), .ovf_o(ovf[0]));

  updown_mod_counter #(.MAX_VALUE(9), .WRAP_MODE(0), .PRESCALE(1)) d1 (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(en[1]), .clear_i(clr[1]), .load_i(ld[1]),
    .load_value_i(lv[1]), .up_i(up[1]), .value_o(val[1]), .tc_o(tc[1]), .ovf_o(ovf[1]));

  updown_mod_counter #(.MAX_VALUE(9), .WRAP_MODE(1), .PRESCALE(4)) d2 (
    .clk_i(clk), .a_rst_n_i(rst_n), .enable_i(en[2]), .clear_i(clr[2]), .load_i(ld[2]),
    .load_value_i(lv[2]), .up_i(up[2]), .value_o(val[2]), .tc_o(tc[2]), .ovf_o(ovf[2]));

  task automatic check(input exp_t e);
    n_total++;
    if (val[e.d] === e.v && tc[e.d] === e.tc && ovf[e.d] === e.ovf) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d: got value=%0d tc=%b ovf=%b, want value=%0d tc=%b ovf=%b",
               e.nm, e.d, val[e.d], tc[e.d], ovf[e.d], e.v, e.tc, e.ovf);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) check(q.pop_front());
  end

  always @(async_ev) begin
    while (q.size() != 0) check(q.pop_front());
  end

  task automatic push(input int d, input logic [3:0] v, input logic t, input logic o,
                      input string nm);
    exp_t e;
    e.d = d; e.v = v; e.tc = t; e.ovf = o; e.nm = nm;
    q.push_back(e);
  endtask

  // Drive one edge worth of inputs on DUT d and queue the state expected after that edge.
  task automatic cyc(input int d, input logic e, input logic c, input logic l,
                     input logic [3:0] lval, input logic u,
                     input logic [3:0] ev, input logic et, input logic eo, input string nm);
    @(negedge clk);
    en[d] = e; clr[d] = c; ld[d] = l; lv[d] = lval; up[d] = u;
    push(d, ev, et, eo, nm);
  endtask

  task automatic idle(input int d);
    en[d] = 1'b0; clr[d] = 1'b0; ld[d] = 1'b0; lv[d] = '0; up[d] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) idle(i);
    #2;
    for (int i = 0; i < 3; i++) push(i, 4'd0, 1'b0, 1'b0, "reset");
    ->async_ev;
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap up through MAX_VALUE=9
    for (int i = 1; i <= 9; i++) cyc(0, 1, 0, 0, 0, 1, 4'(i), 0, 0, "wrap_up");
    cyc(0, 1, 0, 0, 0, 1, 4'd0, 1, 1, "wrap_up_tc");
    cyc(0, 0, 0, 0, 0, 1, 4'd0, 0, 1, "tc_drop");
    cyc(0, 0, 1, 0, 0, 1, 4'd0, 0, 0, "clear");
    cyc(0, 1, 0, 0, 0, 0, 4'd9, 1, 1, "wrap_down_tc");
    cyc(0, 1, 0, 0, 0, 0, 4'd8, 0, 1, "down8");
    cyc(0, 1, 0, 0, 0, 0, 4'd7, 0, 1, "down7");
    cyc(0, 0, 0, 1, 4'd15, 0, 4'd9, 0, 1, "load_clamp");
    cyc(0, 0, 1, 1, 4'd6, 0, 4'd0, 0, 0, "clear_over_load");
    cyc(0, 1, 0, 1, 4'd5, 1, 4'd5, 0, 0, "load_over_step");
    cyc(0, 1, 0, 0, 0, 1, 4'd6, 0, 0, "step_up");
    cyc(0, 1, 0, 0, 0, 0, 4'd5, 0, 0, "dir_change");
    cyc(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "load0");
    cyc(0, 1, 0, 0, 0, 0, 4'd9, 1, 1, "wrap_down2");
    cyc(0, 0, 0, 1, 4'd5, 1, 4'd5, 0, 1, "load_ovf_holds");
    @(negedge clk);
    idle(0);
    #2;
    rst_n = 1'b0;
    #1;
    push(0, 4'd0, 1'b0, 1'b0, "async_reset");
    ->async_ev;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0, 1, 4'd1, 0, 0, "post_reset_step");
    @(negedge clk);
    idle(0);

    // Saturating instance
    cyc(1, 0, 0, 1, 4'd8, 1, 4'd8, 0, 0, "sat_load8");
    cyc(1, 1, 0, 0, 0, 1, 4'd9, 0, 0, "sat_up9");
    cyc(1, 1, 0, 0, 0, 1, 4'd9, 1, 1, "sat_hold1");
    cyc(1, 1, 0, 0, 0, 1, 4'd9, 1, 1, "sat_hold2");
    cyc(1, 0, 1, 0, 0, 1, 4'd0, 0, 0, "sat_clear");
    cyc(1, 1, 0, 0, 0, 0, 4'd0, 1, 1, "sat_down_at0");
    cyc(1, 0, 0, 0, 0, 0, 4'd0, 0, 1, "sat_idle");
    @(negedge clk);
    idle(1);

    // Prescaled instance: one step per 4 enabled edges
    for (int i = 1; i <= 12; i++)
      cyc(2, 1, 0, 0, 0, 1, 4'(i / 4), 0, 0, "ps_count");
    for (int i = 0; i < 5; i++) cyc(2, 0, 0, 0, 0, 1, 4'd3, 0, 0, "ps_frozen");
    cyc(2, 1, 0, 0, 0, 1, 4'd3, 0, 0, "ps_part1");
    cyc(2, 1, 0, 0, 0, 1, 4'd3, 0, 0, "ps_part2");
    cyc(2, 0, 0, 1, 4'd7, 1, 4'd7, 0, 0, "ps_load");
    for (int i = 0; i < 3; i++) cyc(2, 1, 0, 0, 0, 1, 4'd7, 0, 0, "ps_after_load");
    cyc(2, 1, 0, 0, 0, 1, 4'd8, 0, 0, "ps_step_after_load");
    @(negedge clk);
    idle(2);
    @(negedge clk);

    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
